// File: rtl/calendar_day_counter_if.sv
// Load handshake bundle for calendar_day_counter: a new date/month/weekday offered
// with load_valid and accepted on the cycle load_ready is also high.
interface calendar_day_counter_if;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_date;
    logic [3:0] load_mon;
    logic [2:0] load_week;

    modport master (
        output load_valid,
        output load_date,
        output load_mon,
        output load_week,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_date,
        input  load_mon,
        input  load_week,
        output load_ready
    );
endinterface

// File: rtl/calendar_day_counter.sv
// Non-leap-year date/month/weekday tracker advanced by day_tick, with a validated
// date load (RUN -> CHECK -> optional CATCHUP) that never drops or doubles a tick.
module calendar_day_counter #(
    parameter int START_DATE = 1,
    parameter int START_MON  = 1,
    parameter int START_WEEK = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   day_tick,
    calendar_day_counter_if.slave  ld,
    output logic [4:0]             date_out,
    output logic [3:0]             mon_out,
    output logic [2:0]             week_out,
    output logic                   out_valid,
    output logic                   load_err,
    output logic                   month_wrap,
    output logic                   year_wrap
);

    localparam logic [4:0] START_DATE_V = 5'(START_DATE);
    localparam logic [3:0] START_MON_V  = 4'(START_MON);
    localparam logic [2:0] START_WEEK_V = 3'(START_WEEK);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_CHECK   = 2'd1,
        ST_CATCHUP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] date_q, date_d;
    logic [3:0] mon_q, mon_d;
    logic [2:0] week_q, week_d;
    logic [4:0] hold_date_q, hold_date_d;
    logic [3:0] hold_mon_q, hold_mon_d;
    logic [2:0] hold_week_q, hold_week_d;
    logic       pend_q, pend_d;
    logic       load_ready_q, load_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       load_err_q, load_err_d;
    logic       month_wrap_q, month_wrap_d;
    logic       year_wrap_q, year_wrap_d;

    // Month lengths match the downstream week-teller table; 0 marks an illegal month.
    function automatic logic [4:0] days_in(input logic [3:0] m);
        logic [4:0] d;
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
            4'd2:                                       d = 5'd28;
            default:                                    d = 5'd0;
        endcase
        return d;
    endfunction

    // One-day advance of the current value, shared by RUN and CATCHUP.
    logic       adv_last;
    logic [4:0] adv_date;
    logic [3:0] adv_mon;
    logic [2:0] adv_week;
    logic       adv_year;
    logic       hold_legal;

    always_comb begin
        adv_last = (date_q == days_in(mon_q));
        adv_year = adv_last && (mon_q == 4'd12);
        adv_week = (week_q == 3'd6) ? 3'd0 : week_q + 3'd1;
        adv_date = adv_last ? 5'd1 : date_q + 5'd1;
        if (!adv_last) begin
            adv_mon = mon_q;
        end else if (mon_q == 4'd12) begin
            adv_mon = 4'd1;
        end else begin
            adv_mon = mon_q + 4'd1;
        end
        hold_legal = (hold_mon_q >= 4'd1) && (hold_mon_q <= 4'd12) &&
                     (hold_date_q >= 5'd1) && (hold_date_q <= days_in(hold_mon_q)) &&
                     (hold_week_q <= 3'd6);
    end

    always_comb begin
        state_d      = state_q;
        date_d       = date_q;
        mon_d        = mon_q;
        week_d       = week_q;
        hold_date_d  = hold_date_q;
        hold_mon_d   = hold_mon_q;
        hold_week_d  = hold_week_q;
        pend_d       = pend_q;
        load_err_d   = 1'b0;
        month_wrap_d = 1'b0;
        year_wrap_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (day_tick) begin
                    date_d       = adv_date;
                    mon_d        = adv_mon;
                    week_d       = adv_week;
                    month_wrap_d = adv_last;
                    year_wrap_d  = adv_year;
                end
                if (ld.load_valid && load_ready_q) begin
                    hold_date_d = ld.load_date;
                    hold_mon_d  = ld.load_mon;
                    hold_week_d = ld.load_week;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (hold_legal) begin
                    date_d = hold_date_q;
                    mon_d  = hold_mon_q;
                    week_d = hold_week_q;
                end else begin
                    load_err_d = 1'b1;
                end
                // A tick arriving while the load is judged is replayed in CATCHUP.
                pend_d  = pend_q | day_tick;
                state_d = (pend_q || day_tick) ? ST_CATCHUP : ST_RUN;
            end
            ST_CATCHUP: begin
                date_d       = adv_date;
                mon_d        = adv_mon;
                week_d       = adv_week;
                month_wrap_d = adv_last;
                year_wrap_d  = adv_year;
                pend_d       = day_tick;
                state_d      = day_tick ? ST_CATCHUP : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
        endcase

        load_ready_d = (state_d == ST_RUN);
        out_valid_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            date_q       <= START_DATE_V;
            mon_q        <= START_MON_V;
            week_q       <= START_WEEK_V;
            hold_date_q  <= 5'd0;
            hold_mon_q   <= 4'd0;
            hold_week_q  <= 3'd0;
            pend_q       <= 1'b0;
            load_ready_q <= 1'b1;
            out_valid_q  <= 1'b1;
            load_err_q   <= 1'b0;
            month_wrap_q <= 1'b0;
            year_wrap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            date_q       <= date_d;
            mon_q        <= mon_d;
            week_q       <= week_d;
            hold_date_q  <= hold_date_d;
            hold_mon_q   <= hold_mon_d;
            hold_week_q  <= hold_week_d;
            pend_q       <= pend_d;
            load_ready_q <= load_ready_d;
            out_valid_q  <= out_valid_d;
            load_err_q   <= load_err_d;
            month_wrap_q <= month_wrap_d;
            year_wrap_q  <= year_wrap_d;
        end
    end

    assign ld.load_ready = load_ready_q;
    assign date_out      = date_q;
    assign mon_out       = mon_q;
    assign week_out      = week_q;
    assign out_valid     = out_valid_q;
    assign load_err      = load_err_q;
    assign month_wrap    = month_wrap_q;
    assign year_wrap     = year_wrap_q;

endmodule

// File: tb/tb_calendar_day_counter.sv
// Self-checking bench for calendar_day_counter: a table of loads/ticks with a
// scoreboard queue, plus hand sequences for reset defaults and reset during CATCHUP.
module tb_calendar_day_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       day_tick = 1'b0;
    logic [4:0] date_out;
    logic [3:0] mon_out;
    logic [2:0] week_out;
    logic       out_valid, load_err, month_wrap, year_wrap;

    calendar_day_counter_if ld ();

    calendar_day_counter #(
        .START_DATE(1),
        .START_MON (1),
        .START_WEEK(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .day_tick  (day_tick),
        .ld        (ld),
        .date_out  (date_out),
        .mon_out   (mon_out),
        .week_out  (week_out),
        .out_valid (out_valid),
        .load_err  (load_err),
        .month_wrap(month_wrap),
        .year_wrap (year_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d, m, w;
        int tick_chk;
        int n_ticks;
        int ed, em, ew;
        int eerr, emw, eyw, eovl;
    } vec_t;

    vec_t tbl[11];
    vec_t exp_q[$];

    int pass_cnt = 0;
    int check_cnt = 0;
    int err_seen = 0, mw_seen = 0, yw_seen = 0, ov_low = 0;

    // Pulse/valid monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_err)   err_seen++;
            if (month_wrap) mw_seen++;
            if (year_wrap)  yw_seen++;
            if (!out_valid) ov_low++;
        end
    end

    function automatic vec_t mk(int d, int m, int w, int tc, int nt,
                                int ed, int em, int ew,
                                int eerr, int emw, int eyw, int eovl);
        vec_t v;
        v.d = d; v.m = m; v.w = w; v.tick_chk = tc; v.n_ticks = nt;
        v.ed = ed; v.em = em; v.ew = ew;
        v.eerr = eerr; v.emw = emw; v.eyw = eyw; v.eovl = eovl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input int idx, input vec_t v);
        int b_err, b_mw, b_yw, b_ov, n;
        vec_t e;
        exp_q.push_back(v);
        n = 0;
        while (!ld.load_ready && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("v%0d ready_before_load", idx), int'(ld.load_ready), 1);
        b_err = err_seen; b_mw = mw_seen; b_yw = yw_seen; b_ov = ov_low;
        ld.load_valid = 1'b1;
        ld.load_date  = 5'(v.d);
        ld.load_mon   = 4'(v.m);
        ld.load_week  = 3'(v.w);
        step();
        ld.load_valid = 1'b0;
        day_tick      = (v.tick_chk != 0);
        step();
        day_tick = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("v%0d out_valid_return", idx), int'(out_valid), 1);
        for (int t = 0; t < v.n_ticks; t++) begin
            day_tick = 1'b1;
            step();
        end
        day_tick = 1'b0;
        step();
        step();
        e = exp_q.pop_front();
        $display("load %0d: %0d/%0d/%0d tickchk=%0d ticks=%0d -> %0d/%0d/%0d err=%0d mw=%0d yw=%0d ovlow=%0d",
                 idx, e.d, e.m, e.w, e.tick_chk, e.n_ticks, date_out, mon_out, week_out,
                 err_seen - b_err, mw_seen - b_mw, yw_seen - b_yw, ov_low - b_ov);
        chk($sformatf("v%0d date", idx), int'(date_out), e.ed);
        chk($sformatf("v%0d mon", idx), int'(mon_out), e.em);
        chk($sformatf("v%0d week", idx), int'(week_out), e.ew);
        chk($sformatf("v%0d load_err_cycles", idx), err_seen - b_err, e.eerr);
        chk($sformatf("v%0d month_wrap_cycles", idx), mw_seen - b_mw, e.emw);
        chk($sformatf("v%0d year_wrap_cycles", idx), yw_seen - b_yw, e.eyw);
        chk($sformatf("v%0d out_valid_low_cycles", idx), ov_low - b_ov, e.eovl);
    endtask

    initial begin
        int b_err, b_mw, b_yw, b_ov;

        //          d   m  w tc nt  ed em ew err mw yw ovl
        tbl[0]  = mk(28,  2, 5, 0, 1,  1, 3, 6, 0, 1, 0, 1);
        tbl[1]  = mk(31, 12, 6, 0, 1,  1, 1, 0, 0, 1, 1, 1);
        tbl[2]  = mk(10,  5, 2, 0, 0, 10, 5, 2, 0, 0, 0, 1);
        tbl[3]  = mk(30,  2, 1, 0, 0, 10, 5, 2, 1, 0, 0, 1);
        tbl[4]  = mk( 5, 13, 0, 0, 0, 10, 5, 2, 1, 0, 0, 1);
        tbl[5]  = mk(15,  6, 3, 1, 0, 16, 6, 4, 0, 0, 0, 2);
        tbl[6]  = mk( 0,  3, 0, 0, 0, 16, 6, 4, 1, 0, 0, 1);
        tbl[7]  = mk(31,  4, 0, 0, 0, 16, 6, 4, 1, 0, 0, 1);
        tbl[8]  = mk(30,  4, 7, 0, 0, 16, 6, 4, 1, 0, 0, 1);
        tbl[9]  = mk(30,  4, 6, 0, 1,  1, 5, 0, 0, 1, 0, 1);
        tbl[10] = mk( 0,  0, 0, 1, 0,  2, 5, 1, 1, 0, 0, 2);

        ld.load_valid = 1'b0;
        ld.load_date  = 5'd0;
        ld.load_mon   = 4'd0;
        ld.load_week  = 3'd0;

        // Reset defaults
        step();
        step();
        rst_n = 1'b1;
        step();
        $display("reset: %0d/%0d/%0d valid=%0d ready=%0d", date_out, mon_out, week_out, out_valid, ld.load_ready);
        chk("reset date", int'(date_out), 1);
        chk("reset mon", int'(mon_out), 1);
        chk("reset week", int'(week_out), 0);
        chk("reset out_valid", int'(out_valid), 1);
        chk("reset load_ready", int'(ld.load_ready), 1);
        chk("reset pulses", int'({load_err, month_wrap, year_wrap}), 0);

        // Three back-to-back ticks
        b_mw = mw_seen; b_yw = yw_seen; b_ov = ov_low;
        for (int t = 0; t < 3; t++) begin
            day_tick = 1'b1;
            step();
        end
        day_tick = 1'b0;
        step();
        $display("3 ticks: %0d/%0d/%0d", date_out, mon_out, week_out);
        chk("ticks date", int'(date_out), 4);
        chk("ticks mon", int'(mon_out), 1);
        chk("ticks week", int'(week_out), 3);
        chk("ticks out_valid_low_cycles", ov_low - b_ov, 0);
        chk("ticks month_wrap_cycles", mw_seen - b_mw, 0);
        chk("ticks year_wrap_cycles", yw_seen - b_yw, 0);

        for (int i = 0; i < 11; i++) do_load(i, tbl[i]);

        // Reset while in CATCHUP with a further tick pending
        ld.load_valid = 1'b1;
        ld.load_date  = 5'd15;
        ld.load_mon   = 4'd6;
        ld.load_week  = 3'd3;
        step();
        ld.load_valid = 1'b0;
        day_tick      = 1'b1;
        step();
        chk("catchup out_valid_low", int'(out_valid), 0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset in catchup: %0d/%0d/%0d valid=%0d ready=%0d", date_out, mon_out, week_out, out_valid, ld.load_ready);
        chk("async reset date", int'(date_out), 1);
        chk("async reset mon", int'(mon_out), 1);
        chk("async reset week", int'(week_out), 0);
        chk("async reset load_ready", int'(ld.load_ready), 1);
        chk("async reset out_valid", int'(out_valid), 1);
        day_tick = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        b_err = err_seen; b_mw = mw_seen; b_yw = yw_seen; b_ov = ov_low;
        step();
        step();
        step();
        $display("after release: %0d/%0d/%0d", date_out, mon_out, week_out);
        chk("release date", int'(date_out), 1);
        chk("release week", int'(week_out), 0);
        chk("release pulses", (err_seen - b_err) + (mw_seen - b_mw) + (yw_seen - b_yw), 0);
        chk("release out_valid_low_cycles", ov_low - b_ov, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
